// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like slave port between the instruction
// fetch requester and the data requester, one transaction in flight at a time.
// Optional macro ARB_ROUND_ROBIN_EN: ties in IDLE alternate between the two
// requesters instead of always going to the data side.
module sram_req_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // instruction-fetch requester
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // data requester
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // slave port
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e            state_q;
  state_e            state_d;
  logic              owner_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_data_c;
  logic              grant_inst_c;
  logic              data_ok_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Remember which side won the most recent grant so a tie goes to the other
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_q <= OWN_INST;
    end else if (grant_data_c) begin
      last_grant_q <= OWN_DATA;
    end else if (grant_inst_c) begin
      last_grant_q <= OWN_INST;
    end
  end

  // Grant decision: alternate on a tie, single requests win immediately
  always_comb begin
    grant_data_c = 1'b0;
    grant_inst_c = 1'b0;
    if (resetn && (state_q == S_IDLE)) begin
      if (data_req && inst_req) begin
        grant_data_c = (last_grant_q == OWN_INST);
        grant_inst_c = (last_grant_q == OWN_DATA);
      end else begin
        grant_data_c = data_req;
        grant_inst_c = inst_req;
      end
    end
  end
`else
  // Grant decision: data always beats instruction fetch
  always_comb begin
    grant_data_c = 1'b0;
    grant_inst_c = 1'b0;
    if (resetn && (state_q == S_IDLE)) begin
      grant_data_c = data_req;
      grant_inst_c = inst_req && !data_req;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (grant_data_c || grant_inst_c) state_d = S_ADDR;
      S_ADDR: if (m_addr_ok) state_d = S_DATA;
      S_DATA: if (m_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the granted request so the slave sees stable fields
  always_ff @(posedge clk) begin
    if (!resetn) begin
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_data_c) begin
      owner_q <= OWN_DATA;
      wr_q    <= data_wr;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wdata_q <= data_wdata;
    end else if (grant_inst_c) begin
      owner_q <= OWN_INST;
      wr_q    <= inst_wr;
      size_q  <= inst_size;
      addr_q  <= inst_addr;
      wdata_q <= inst_wdata;
    end
  end

  // Outputs: slave fields only while presenting an address, response routed to owner
  always_comb begin
    inst_addr_ok = grant_inst_c;
    data_addr_ok = grant_data_c;
    m_req        = 1'b0;
    m_wr         = 1'b0;
    m_size       = 2'd0;
    m_addr       = '0;
    m_wdata      = '0;
    data_ok_c    = resetn && (state_q == S_DATA) && m_data_ok;
    inst_data_ok = data_ok_c && (owner_q == OWN_INST);
    data_data_ok = data_ok_c && (owner_q == OWN_DATA);
    inst_rdata   = m_rdata;
    data_rdata   = m_rdata;
    busy         = (state_q != S_IDLE);
    if (state_q == S_ADDR) begin
      m_req   = 1'b1;
      m_wr    = wr_q;
      m_size  = size_q;
      m_addr  = addr_q;
      m_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level reference model of the arbiter.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one pending transaction plus the last winner
  logic        md_have      = 1'b0;
  logic        md_addr_done = 1'b0;
  logic        md_owner     = 1'b0;
  logic        md_last      = 1'b0;
  logic        md_wr;
  logic [1:0]  md_size;
  logic [31:0] md_addr, md_wdata;

  // values sampled during the most recent tick
  logic        s_inst_addr_ok, s_data_addr_ok, s_inst_data_ok, s_data_data_ok;
  logic        s_m_req, s_m_wr, s_busy;
  logic [31:0] s_m_addr, s_m_wdata, s_inst_rdata;

  int grants[$];

  sram_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs are already applied; compare at negedge, advance model at posedge
  task automatic tick();
    logic prefer_data, idle, exp_gd, exp_gi, exp_dok;
    @(negedge clk);
    idle        = !md_have;
    prefer_data = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    prefer_data = (md_last == 1'b0);
`endif
    exp_gd  = resetn && idle && data_req && (!inst_req || prefer_data);
    exp_gi  = resetn && idle && inst_req && !exp_gd;
    exp_dok = resetn && md_have && md_addr_done && m_data_ok;

    check("data_addr_ok", 32'(data_addr_ok), 32'(exp_gd));
    check("inst_addr_ok", 32'(inst_addr_ok), 32'(exp_gi));
    check("m_req", 32'(m_req), 32'(md_have && !md_addr_done));
    check("busy", 32'(busy), 32'(md_have));
    check("data_data_ok", 32'(data_data_ok), 32'(exp_dok && md_owner));
    check("inst_data_ok", 32'(inst_data_ok), 32'(exp_dok && !md_owner));
    if (md_have && !md_addr_done) begin
      check("m_addr", m_addr, md_addr);
      check("m_wr", 32'(m_wr), 32'(md_wr));
      check("m_size", 32'(m_size), 32'(md_size));
      check("m_wdata", m_wdata, md_wdata);
    end
    if (exp_dok) begin
      if (md_owner) check("data_rdata", data_rdata, m_rdata);
      else          check("inst_rdata", inst_rdata, m_rdata);
    end

    s_inst_addr_ok = inst_addr_ok;  s_data_addr_ok = data_addr_ok;
    s_inst_data_ok = inst_data_ok;  s_data_data_ok = data_data_ok;
    s_m_req = m_req;  s_m_wr = m_wr;  s_busy = busy;
    s_m_addr = m_addr;  s_m_wdata = m_wdata;  s_inst_rdata = inst_rdata;

    @(posedge clk);
    if (!resetn) begin
      md_have = 1'b0;  md_addr_done = 1'b0;  md_last = 1'b0;
    end else if (exp_gd || exp_gi) begin
      md_have = 1'b1;  md_addr_done = 1'b0;  md_owner = exp_gd;  md_last = exp_gd;
      md_wr    = exp_gd ? data_wr    : inst_wr;
      md_size  = exp_gd ? data_size  : inst_size;
      md_addr  = exp_gd ? data_addr  : inst_addr;
      md_wdata = exp_gd ? data_wdata : inst_wdata;
    end else if (md_have && !md_addr_done && m_addr_ok) begin
      md_addr_done = 1'b1;
    end else if (exp_dok) begin
      md_have = 1'b0;
    end
    #1;
  endtask

  // Let any pending transaction complete with a fast slave
  task automatic drain();
    data_req = 1'b0;  inst_req = 1'b0;
    m_addr_ok = 1'b1;  m_data_ok = 1'b1;
    repeat (3) tick();
    m_addr_ok = 1'b0;  m_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 1'b1;  inst_wr = 1'b0;  inst_size = 2'd2;  inst_addr = 32'h0;  inst_wdata = 32'h0;
    data_req = 1'b1;  data_wr = 1'b0;  data_size = 2'd2;  data_addr = 32'h0;  data_wdata = 32'h0;
    m_addr_ok = 1'b0;  m_data_ok = 1'b0;  m_rdata = 32'h0;
    @(posedge clk);  #1;

    // reset held with both requests high
    repeat (3) tick();
    check("rst_data_addr_ok", 32'(s_data_addr_ok), 32'd0);
    check("rst_inst_addr_ok", 32'(s_inst_addr_ok), 32'd0);
    check("rst_m_req", 32'(s_m_req), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    resetn = 1'b1;
    tick();
    check("rel_data_addr_ok", 32'(s_data_addr_ok), 32'd1);
    drain();

    // lone instruction read, fastest slave
    inst_req = 1'b1;  inst_wr = 1'b0;  inst_size = 2'd2;  inst_addr = 32'hbfc00000;
    m_addr_ok = 1'b1;
    tick();
    check("ir_addr_ok", 32'(s_inst_addr_ok), 32'd1);
    inst_req = 1'b0;
    tick();
    check("ir_m_req", 32'(s_m_req), 32'd1);
    check("ir_m_addr", s_m_addr, 32'hbfc00000);
    m_addr_ok = 1'b0;  m_data_ok = 1'b1;  m_rdata = 32'h3c010000;
    tick();
    check("ir_data_ok", 32'(s_inst_data_ok), 32'd1);
    check("ir_rdata", s_inst_rdata, 32'h3c010000);
    check("ir_no_ddok", 32'(s_data_data_ok), 32'd0);
    m_data_ok = 1'b0;

    // simultaneous requests: data write wins
    inst_req = 1'b1;  inst_addr = 32'hbfc00004;
    data_req = 1'b1;  data_wr = 1'b1;  data_size = 2'd2;
    data_addr = 32'h1faf0000;  data_wdata = 32'h12345678;
    m_addr_ok = 1'b1;
    tick();
    check("tie_data_win", 32'(s_data_addr_ok), 32'd1);
    check("tie_inst_lose", 32'(s_inst_addr_ok), 32'd0);
    data_req = 1'b0;
    tick();
    check("tie_m_addr", s_m_addr, 32'h1faf0000);
    check("tie_m_wr", 32'(s_m_wr), 32'd1);
    check("tie_m_wdata", s_m_wdata, 32'h12345678);
    m_addr_ok = 1'b0;  m_data_ok = 1'b1;
    tick();
    check("tie_ddok", 32'(s_data_data_ok), 32'd1);
    check("tie_no_iaok", 32'(s_inst_addr_ok), 32'd0);
    m_data_ok = 1'b0;
    tick();
    check("tie_inst_next", 32'(s_inst_addr_ok), 32'd1);
    drain();

    // slave stalls the address phase for 4 cycles
    inst_req = 1'b1;  inst_wr = 1'b0;  inst_addr = 32'hbfc00100;
    tick();
    inst_req = 1'b0;
    data_req = 1'b1;  data_wr = 1'b0;  data_addr = 32'h00001000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_m_req", 32'(s_m_req), 32'd1);
      check("stall_m_addr", s_m_addr, 32'hbfc00100);
      check("stall_no_daok", 32'(s_data_addr_ok), 32'd0);
    end
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;  m_data_ok = 1'b1;
    tick();
    check("stall_idok", 32'(s_inst_data_ok), 32'd1);
    m_data_ok = 1'b0;
    tick();
    check("stall_daok_after", 32'(s_data_addr_ok), 32'd1);
    drain();

    // spurious m_data_ok in IDLE, then reset while in DATA
    m_data_ok = 1'b1;
    tick();
    check("spur_idok", 32'(s_inst_data_ok), 32'd0);
    check("spur_ddok", 32'(s_data_data_ok), 32'd0);
    check("spur_busy", 32'(s_busy), 32'd0);
    m_data_ok = 1'b0;
    inst_req = 1'b1;  m_addr_ok = 1'b1;
    tick();
    inst_req = 1'b0;
    tick();
    m_addr_ok = 1'b0;  m_data_ok = 1'b1;  resetn = 1'b0;
    tick();
    check("rstdata_idok", 32'(s_inst_data_ok), 32'd0);
    resetn = 1'b1;
    tick();
    check("post_rst_idok", 32'(s_inst_data_ok), 32'd0);
    check("post_rst_busy", 32'(s_busy), 32'd0);
    m_data_ok = 1'b0;

    // both sides requesting continuously: grant order
    inst_req = 1'b1;  data_req = 1'b1;
    m_addr_ok = 1'b1;  m_data_ok = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_data_addr_ok) grants.push_back(1);
      else if (s_inst_addr_ok) grants.push_back(0);
    end
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      check("grant_order", 32'((i < grants.size()) ? grants[i] : -1), 32'((i % 2 == 0) ? 1 : 0));
`else
      check("grant_order", 32'((i < grants.size()) ? grants[i] : -1), 32'd1);
`endif
    end
    drain();

    // randomized traffic with random slave timing and occasional reset
    for (int c = 0; c < 4000; c++) begin
      if (!data_req || s_data_addr_ok) begin
        data_req   = ($urandom_range(0, 2) != 0);
        data_wr    = 1'($urandom);
        data_size  = 2'($urandom_range(0, 2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
      if (!inst_req || s_inst_addr_ok) begin
        inst_req   = ($urandom_range(0, 2) != 0);
        inst_wr    = ($urandom_range(0, 7) == 0);
        inst_size  = 2'($urandom_range(0, 2));
        inst_addr  = $urandom;
        inst_wdata = $urandom;
      end
      m_addr_ok = 1'($urandom);
      m_data_ok = 1'($urandom);
      m_rdata   = $urandom;
      resetn    = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like slave port between the instruction-fetch requester and the data-access requester. The fetch requester is driven by the IF stage; the data requester is driven by EXE/MEM. The slave is the downstream bus bridge.
Allows only one outstanding transaction at a time. The arbiter latches the winning request, presents it to the slave, waits for the address phase, then waits for the data phase, and returns the response to the owner.
Fixed data-over-instruction priority by default.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active-low
inst_req  in  1  fetch request valid
inst_wr  in  1  fetch write flag (normally 0)
inst_size  in  2  access size (0: byte, 1: half, 2: word)
inst_addr  in  ADDR_W  fetch address
inst_wdata  in  DATA_W  fetch write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  DATA_W  fetch read data
data_req  in  1  data request valid
data_wr  in  1  data write flag
data_size  in  2  access size
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  data write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid this cycle
data_rdata  out  DATA_W  data read data
m_req  out  1  slave request valid
m_wr  out  1  slave write flag
m_size  out  2  slave size
m_addr  out  ADDR_W  slave address
m_wdata  out  DATA_W  slave write data
m_addr_ok  in  1  slave accepted address
m_data_ok  in  1  slave response valid
m_rdata  in  DATA_W  slave read data
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, clk. resetn is synchronous and active-low. All state updates on the rising edge of clk.
- States: IDLE, ADDR, DATA. An owner register (INST/DATA) and latched request registers (wr, size, addr, wdata) hold the accepted request.
- Reset (resetn=0 at a clock edge):
  - state=IDLE, owner=INST, all latched registers cleared.
  - All outputs are 0 while in IDLE with no request.
  - A transaction in flight at reset is dropped. No data_ok is issued for it, and any later m_data_ok is ignored.
- IDLE:
  - If data_req=1: data_addr_ok=1 combinationally in that cycle. Latch the data_* fields, owner=DATA, go to ADDR.
  - Otherwise, if inst_req=1: same behaviour for inst, owner=INST.
  - Only the granted side sees addr_ok. The loser holds its req.
- ADDR:
  - m_req=1 with the latched fields driven from registers.
  - On m_addr_ok=1, go to DATA. Otherwise stay; m_* fields remain stable.
- DATA:
  - m_req=0.
  - On m_data_ok=1: the owner's data_ok=1 in that same cycle, and the owner's rdata = m_rdata (combinational). Go to IDLE.
- addr_ok is never asserted outside IDLE. A new grant is possible only in the cycle after data_ok.
- inst_rdata and data_rdata both carry m_rdata continuously. They are valid only when qualified by the respective data_ok.
- m_data_ok outside DATA is ignored: no state change and no data_ok output.
- Minimum latency, cycle numbering from the accept cycle:
  - cycle 0: accept (addr_ok)
  - cycle 1: m_req asserted; m_addr_ok same cycle is allowed
  - cycle 2: earliest m_data_ok, which produces the requester's data_ok
  - Minimum turnaround is 3 cycles per transaction.
- Writes follow the same sequence. The data_ok for a write carries no meaningful rdata.
- busy=1 in ADDR or DATA.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a tie in IDLE (both req=1) is granted to the side that did not win the previous grant. The last-grant register resets to INST, so the first tie goes to DATA. Single requests are granted immediately.
- Undefined: fixed priority, data always wins a tie. No last-grant register is built.

Test Plan:
- Reset with resetn=0 for 3 cycles, both reqs high → no addr_ok, m_req=0, busy=0. After release, data_addr_ok pulses in the first cycle.
- Inst read alone, addr=0xbfc00000, slave addr_ok immediately and data_ok one cycle later with rdata=0x3c010000 → inst_addr_ok at cycle 0, m_req at cycle 1 with m_addr=0xbfc00000, inst_data_ok at cycle 2 with inst_rdata=0x3c010000, data_data_ok stays 0.
- Both request in the same cycle (inst 0xbfc00004, data write 0x1faf0000, wdata 0x12345678, size 2), fixed priority → data granted first: m_addr=0x1faf0000, m_wr=1, m_wdata=0x12345678. inst_addr_ok only in the cycle after data_data_ok.
- Slave stalls m_addr_ok for 4 cycles → m_req and m_addr stay stable for all 4 cycles. No second addr_ok while the first transaction is pending.
- Spurious m_data_ok in IDLE, then resetn=0 while in DATA → no data_ok output in either case, state returns to IDLE, and a later m_data_ok is ignored.
- With ARB_ROUND_ROBIN_EN, both sides requesting continuously → grants alternate DATA, INST, DATA, INST over 4 transactions.
